// File: rtl/alsu_sched_pkg.sv
// rtl/alsu_sched_pkg.sv - command layout, opcodes, states and idle drive for the ALSU request scheduler
package alsu_sched_pkg;

    localparam int CMD_W     = 19;
    localparam int OFF_OP    = 0;
    localparam int OFF_A     = 3;
    localparam int OFF_B     = 6;
    localparam int OFF_CIN   = 9;
    localparam int OFF_RED_A = 10;
    localparam int OFF_RED_B = 11;
    localparam int OFF_BYP_A = 12;
    localparam int OFF_BYP_B = 13;
    localparam int OFF_DIR   = 14;
    localparam int OFF_SIN   = 15;
    localparam int OFF_CNT   = 16;

    localparam logic [2:0] OP_OR    = 3'd0;
    localparam logic [2:0] OP_XOR   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MULT  = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;
    localparam logic [2:0] OP_ROT   = 3'd5;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] opcode;
        logic       cin;
        logic       red_a;
        logic       red_b;
        logic       byp_a;
        logic       byp_b;
        logic       dir;
        logic       sin;
    } drive_t;

    // Bypassing A=0 makes the ALSU settle to out = 0 between commands.
    localparam drive_t IDLE_DRIVE = '{a: 3'd0, b: 3'd0, opcode: OP_OR, cin: 1'b0,
                                      red_a: 1'b0, red_b: 1'b0, byp_a: 1'b1, byp_b: 1'b0,
                                      dir: 1'b0, sin: 1'b0};

    function automatic logic is_invalid_cmd(input logic [2:0] op, input logic red_any,
                                            input logic byp_any);
        return !byp_any && ((op >= 3'd6) || (red_any && (op >= OP_ADD)));
    endfunction

endpackage

// File: rtl/alsu_req_scheduler_rr_arbiter.sv
// rtl/alsu_req_scheduler_rr_arbiter.sv - round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int s;
            logic [ID_W-1:0] j;
            s = int'(ptr) + k;
            if (s >= NREQ) s = s - NREQ;
            j = ID_W'(s);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/alsu_req_scheduler.sv
// rtl/alsu_req_scheduler.sv - shares one ALSU between NREQ requesters with a valid/ready response channel
module alsu_req_scheduler
    import alsu_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int ALSU_LAT = 2,
    parameter int ID_W     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CMD_W-1:0] req_cmd,
    output logic [NREQ-1:0]      gnt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [5:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [2:0]           alsu_A,
    output logic [2:0]           alsu_B,
    output logic [2:0]           alsu_opcode,
    output logic                 alsu_cin,
    output logic                 alsu_red_op_A,
    output logic                 alsu_red_op_B,
    output logic                 alsu_bypass_A,
    output logic                 alsu_bypass_B,
    output logic                 alsu_direction,
    output logic                 alsu_serial_in,
    input  logic [5:0]           alsu_out
);

    localparam int CNT_W = $clog2(ALSU_LAT + 8);

    state_t            state, state_d;
    logic [ID_W-1:0]   ptr, arb_idx;
    logic [NREQ-1:0]   arb_gnt;
    logic              arb_any;
    logic [CMD_W-1:0]  cmds [NREQ];
    logic [CMD_W-1:0]  sel_cmd;
    logic [2:0]        sel_cnt;
    logic              sel_invalid;
    logic [CNT_W-1:0]  cnt_q;
    logic              start, capture;
    drive_t            drv, sel_drv;

    for (genvar g = 0; g < NREQ; g++) begin : g_cmd
        assign cmds[g] = req_cmd[g*CMD_W +: CMD_W];
    end

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel_cmd     = cmds[arb_idx];
    assign sel_cnt     = (sel_cmd[OFF_CNT +: 3] == 3'd0) ? 3'd1 : sel_cmd[OFF_CNT +: 3];
    assign sel_invalid = is_invalid_cmd(sel_cmd[OFF_OP +: 3],
                                        sel_cmd[OFF_RED_A] | sel_cmd[OFF_RED_B],
                                        sel_cmd[OFF_BYP_A] | sel_cmd[OFF_BYP_B]);
    assign sel_drv = '{a: sel_cmd[OFF_A +: 3], b: sel_cmd[OFF_B +: 3],
                       opcode: sel_cmd[OFF_OP +: 3], cin: sel_cmd[OFF_CIN],
                       red_a: sel_cmd[OFF_RED_A], red_b: sel_cmd[OFF_RED_B],
                       byp_a: sel_cmd[OFF_BYP_A], byp_b: sel_cmd[OFF_BYP_B],
                       dir: sel_cmd[OFF_DIR], sin: sel_cmd[OFF_SIN]};

    assign start   = (state == IDLE) && arb_any;
    assign capture = ((state == ISSUE) || (state == WAIT)) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (arb_any) state_d = sel_invalid ? RESP : ISSUE;
            ISSUE: state_d = capture ? RESP : WAIT;
            WAIT:  if (capture) state_d = RESP;
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The drive register is only written at grant and capture, so the ALSU sees a
    // constant command for the whole latency-plus-iterations window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt      <= '0;
            ptr      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            cnt_q    <= '0;
            drv      <= IDLE_DRIVE;
        end else begin
            gnt <= '0;
            if (start) begin
                gnt      <= arb_gnt;
                ptr      <= (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                rsp_id   <= arb_idx;
                rsp_err  <= sel_invalid;
                rsp_data <= '0;
                cnt_q    <= CNT_W'(ALSU_LAT - 1) + CNT_W'(sel_cnt);
                if (!sel_invalid) drv <= sel_drv;
            end else if (capture) begin
                rsp_data <= alsu_out;
                drv      <= IDLE_DRIVE;
            end else if ((state == ISSUE) || (state == WAIT)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign rsp_valid      = (state == RESP);
    assign busy           = (state != IDLE);
    assign alsu_A         = drv.a;
    assign alsu_B         = drv.b;
    assign alsu_opcode    = drv.opcode;
    assign alsu_cin       = drv.cin;
    assign alsu_red_op_A  = drv.red_a;
    assign alsu_red_op_B  = drv.red_b;
    assign alsu_bypass_A  = drv.byp_a;
    assign alsu_bypass_B  = drv.byp_b;
    assign alsu_direction = drv.dir;
    assign alsu_serial_in = drv.sin;

endmodule

// File: tb/tb_alsu_req_scheduler.sv
// tb/tb_alsu_req_scheduler.sv - directed bench for alsu_req_scheduler with a two-stage ALSU model
module tb_alsu_req_scheduler;

    localparam int NREQ = 4;
    localparam int CW   = 19;
    localparam logic [31:0] IDLE_V = 32'h0008;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ*CW-1:0] req_cmd;
    logic [NREQ-1:0] gnt;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_id;
    logic [5:0]      rsp_data;
    logic            rsp_err, busy;
    logic [2:0]      alsu_A, alsu_B, alsu_opcode;
    logic            alsu_cin, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic            alsu_direction, alsu_serial_in;
    logic [5:0]      alsu_out;

    logic [15:0] drv, in_r;
    logic [5:0]  out_r;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alsu_req_scheduler #(.NREQ(NREQ), .ALSU_LAT(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
        .alsu_cin(alsu_cin), .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_direction(alsu_direction), .alsu_serial_in(alsu_serial_in),
        .alsu_out(alsu_out)
    );

    assign drv = {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_red_op_A, alsu_red_op_B,
                  alsu_bypass_A, alsu_bypass_B, alsu_direction, alsu_serial_in};

    function automatic logic [5:0] alsu_f(input logic [15:0] v, input logic [5:0] o);
        logic signed [5:0] sa, sb;
        sa = {{3{v[15]}}, v[15:13]};
        sb = {{3{v[12]}}, v[12:10]};
        if (v[3]) return {3'b0, v[15:13]};
        if (v[2]) return {3'b0, v[12:10]};
        case (v[9:7])
            3'd0: return v[5] ? {5'b0, |v[15:13]} : v[4] ? {5'b0, |v[12:10]} : {3'b0, v[15:13] | v[12:10]};
            3'd1: return v[5] ? {5'b0, ^v[15:13]} : v[4] ? {5'b0, ^v[12:10]} : {3'b0, v[15:13] ^ v[12:10]};
            3'd2: return sa + sb + {5'b0, v[6]};
            3'd3: return sa * sb;
            3'd4: return v[1] ? {o[4:0], v[0]} : {v[0], o[5:1]};
            3'd5: return v[1] ? {o[4:0], o[5]} : {o[0], o[5:1]};
            default: return 6'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        in_r  <= drv;
        out_r <= alsu_f(in_r, out_r);
    end
    assign alsu_out = out_r;

    function automatic logic [18:0] mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                       input logic cin, input logic dir, input logic sin,
                                       input logic [2:0] cnt);
        return {cnt, sin, dir, 1'b0, 1'b0, 1'b0, 1'b0, cin, b, a, op};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input int i, input logic [18:0] cmd);
        req_cmd[i*CW +: CW] = cmd;
        req[i] = 1'b1;
    endtask

    task automatic wait_gnt(input logic [3:0] exp, input string tag);
        int n = 0;
        tick();
        while (gnt == '0 && n < 30) begin
            tick();
            n++;
        end
        chk(tag, 32'(gnt), 32'(exp));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b0; req = '0; req_cmd = '0; rsp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drive", 32'(drv), IDLE_V);
        rst = 1'b1;
        tick();

        // ADD 3+2+1 from requester 0
        issue(0, mk(3'd2, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0));
        tick();
        req = '0;
        chk("add_gnt", 32'(gnt), 32'h1);
        chk("add_busy", 32'(busy), 32'd1);
        chk("add_op", 32'(alsu_opcode), 32'd2);
        chk("add_a", 32'(alsu_A), 32'd3);
        tick();
        chk("add_v2", 32'(rsp_valid), 32'd0);
        tick();
        chk("add_v3", 32'(rsp_valid), 32'd0);
        chk("add_hold", 32'(alsu_opcode), 32'd2);
        tick();
        chk("add_v4", 32'(rsp_valid), 32'd1);
        chk("add_id", 32'(rsp_id), 32'd0);
        chk("add_data", 32'(rsp_data), 32'h06);
        chk("add_err", 32'(rsp_err), 32'd0);
        chk("add_idle_drv", 32'(drv), IDLE_V);
        tick();
        chk("add_drop", 32'(rsp_valid), 32'd0);
        chk("add_nbusy", 32'(busy), 32'd0);

        // signed MULT -1 * 2
        issue(1, mk(3'd3, 3'd7, 3'd2, 1'b0, 1'b0, 1'b0, 3'd1));
        tick();
        req = '0;
        chk("mul_gnt", 32'(gnt), 32'h2);
        repeat (3) tick();
        chk("mul_valid", 32'(rsp_valid), 32'd1);
        chk("mul_id", 32'(rsp_id), 32'd1);
        chk("mul_data", 32'(rsp_data), 32'h3E);
        tick();

        // SHIFT left, serial in 1, three iterations
        issue(2, mk(3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3));
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                chk("sh_gnt", 32'(gnt), 32'h4);
                req = '0;
            end
            chk($sformatf("sh_op_%0d", k), 32'(alsu_opcode), 32'd4);
        end
        chk("sh_v5", 32'(rsp_valid), 32'd0);
        tick();
        chk("sh_v6", 32'(rsp_valid), 32'd1);
        chk("sh_data", 32'(rsp_data), 32'h07);
        chk("sh_id", 32'(rsp_id), 32'd2);
        tick();

        // invalid opcode 6
        rsp_ready = 1'b0;
        issue(2, mk(3'd6, 3'd5, 3'd5, 1'b0, 1'b0, 1'b0, 3'd0));
        tick();
        req = '0;
        chk("inv_gnt", 32'(gnt), 32'h4);
        chk("inv_valid", 32'(rsp_valid), 32'd1);
        chk("inv_err", 32'(rsp_err), 32'd1);
        chk("inv_data", 32'(rsp_data), 32'd0);
        chk("inv_id", 32'(rsp_id), 32'd2);
        chk("inv_drv1", 32'(drv), IDLE_V);
        tick();
        chk("inv_valid2", 32'(rsp_valid), 32'd1);
        chk("inv_err2", 32'(rsp_err), 32'd1);
        chk("inv_drv2", 32'(drv), IDLE_V);
        rsp_ready = 1'b1;
        tick();
        chk("inv_drop", 32'(rsp_valid), 32'd0);

        // round robin ordering
        for (int i = 0; i < NREQ; i++) req_cmd[i*CW +: CW] = mk(3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0);
        req = 4'b0101;
        wait_gnt(4'b0001, "rr_0");
        req = 4'b0100;
        wait_gnt(4'b0100, "rr_2");
        req = 4'b1111;
        wait_gnt(4'b1000, "rr_3");
        wait_gnt(4'b0001, "rr_0b");
        wait_gnt(4'b0010, "rr_1");
        req = '0;
        wait_idle("rr_idle");

        // back-pressure, then reset mid-WAIT
        rsp_ready = 1'b0;
        issue(2, mk(3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0));
        wait_gnt(4'b0100, "bp_gnt");
        req = '0;
        begin
            int n = 0;
            while (!rsp_valid && n < 20) begin
                tick();
                n++;
            end
        end
        req[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp_valid_%0d", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_data_%0d", k), 32'(rsp_data), 32'h02);
            chk($sformatf("bp_nognt_%0d", k), 32'(gnt), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_drop", 32'(rsp_valid), 32'd0);
        tick();
        chk("bp_gnt0", 32'(gnt), 32'h1);
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_valid", 32'(rsp_valid), 32'd0);
        chk("mr_drv", 32'(drv), IDLE_V);
        chk("mr_gnt", 32'(gnt), 32'd0);
        rst = 1'b1;
        req = 4'b0011;
        wait_gnt(4'b0001, "ptr_reset");
        req = '0;
        wait_idle("end_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
